fir_coef_ctrl: RTL and testbench

Configuration controller for the 16-tap FIR datapath (`filter`). It accepts coefficient writes from a host over a valid/ready port into a shadow bank, then swaps the full set into the active bank atomically on commit. After reset and after every swap it qualifies the filter output with `yn_valid` until the delay line has flushed. It sits between the host/config bus and the FIR's coefficient inputs and output-valid logic.

---
 rtl/fir_ctrl_pkg.sv | 32 +++
 rtl/fir_coef_bank.sv | 45 ++++
 rtl/fir_coef_ctrl.sv | 130 +++++++++++++
 tb/tb_fir_coef_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared constants, types and helpers for the FIR coefficient controller.
// Optional flush sequencing is selected in fir_coef_ctrl by FIR_CTRL_FLUSH_EN.
package fir_ctrl_pkg;

    localparam int unsigned TAPS      = 16;
    localparam int unsigned COEF_W    = 16;
    localparam int unsigned LATENCY   = 4;
    localparam int unsigned FLUSH_CYC = TAPS + LATENCY - 1;
    localparam int unsigned ADDR_W    = $clog2(TAPS);
    localparam int unsigned CNT_W     = $clog2(FLUSH_CYC);
    localparam int unsigned FLAT_W    = TAPS * COEF_W;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic [TAPS-1:0]          tap_mask_t;

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_RUN,
        ST_SWAP
    } fir_ctrl_state_e;

    // Single coefficient write as seen by the bank
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        coef_t             data;
    } cfg_wr_t;

    function automatic tap_mask_t tap_onehot(input logic [ADDR_W-1:0] addr);
        tap_onehot = tap_mask_t'(1) << addr;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient storage: host writes land in the shadow bank and a
// swap strobe copies the complete set into the active bank in one clock.
module fir_coef_bank
    import fir_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  cfg_wr_t           wr,
    input  logic              swap,
    output logic [FLAT_W-1:0] active_flat,
    output logic              commit_ok_c
);

    coef_t     shadow [TAPS];
    coef_t     active [TAPS];
    tap_mask_t mask;

    // Reset leaves a pass-through filter (tap0 = 1) and discards any partial load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= (k == 0) ? coef_t'(1) : coef_t'(0);
            end
            mask <= '0;
        end else if (swap) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                active[k] <= shadow[k];
            end
            mask <= '0;
        end else if (wr_en) begin
            shadow[wr.addr] <= wr.data;
            mask[wr.addr]   <= 1'b1;
        end
    end

    // A commit is good when this write fills the last missing tap (or all are present)
    assign commit_ok_c = &(mask | tap_onehot(wr.addr));

    for (genvar k = 0; k < TAPS; k++) begin : g_flat
        assign active_flat[k*COEF_W +: COEF_W] = active[k];
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient load/commit controller for the 16-tap FIR with output-valid qualification.
// Define FIR_CTRL_FLUSH_EN to hold yn_valid low while the delay line flushes.
module fir_coef_ctrl
    import fir_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  coef_t             cfg_data,
    input  logic              cfg_last,
    output logic [FLAT_W-1:0] coef_flat,
    output logic              yn_valid,
    output logic              swap_done,
    output logic              cfg_err
);

`ifdef FIR_CTRL_FLUSH_EN
    localparam fir_ctrl_state_e RESET_ST   = ST_FLUSH;
    localparam fir_ctrl_state_e AFTER_SWAP = ST_FLUSH;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);
`else
    localparam fir_ctrl_state_e RESET_ST   = ST_RUN;
    localparam fir_ctrl_state_e AFTER_SWAP = ST_RUN;
`endif

    fir_ctrl_state_e state;
    fir_ctrl_state_e state_nxt;
    logic            xfer_c;
    logic            commit_ok_c;
    logic            commit_c;
    logic            reject_c;
    logic            swap_c;
    cfg_wr_t         wr_c;

    assign xfer_c   = cfg_valid && cfg_ready;
    assign commit_c = xfer_c && cfg_last && commit_ok_c;
    assign reject_c = xfer_c && cfg_last && !commit_ok_c;
    assign wr_c     = '{addr: cfg_addr, data: cfg_data};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RESET_ST;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef FIR_CTRL_FLUSH_EN
    logic [CNT_W-1:0] flush_cnt;

    // Flush countdown, reloaded on every swap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt <= FLUSH_LOAD;
        end else if (state == ST_SWAP) begin
            flush_cnt <= FLUSH_LOAD;
        end else if (state == ST_FLUSH && flush_cnt != '0) begin
            flush_cnt <= flush_cnt - CNT_W'(1);
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (commit_c) begin
                    state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                state_nxt = AFTER_SWAP;
            end
`ifdef FIR_CTRL_FLUSH_EN
            ST_FLUSH: begin
                if (flush_cnt == '0) begin
                    state_nxt = ST_RUN;
                end
            end
`endif
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        cfg_ready = 1'b0;
        yn_valid  = 1'b0;
        swap_c    = 1'b0;
        case (state)
            ST_RUN: begin
                cfg_ready = 1'b1;
                yn_valid  = 1'b1;
            end
            ST_SWAP: begin
                swap_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Event pulses land in the cycle after their cause, alongside the new bank
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            swap_done <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            swap_done <= swap_c;
            cfg_err   <= reject_c;
        end
    end

    fir_coef_bank u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (xfer_c),
        .wr          (wr_c),
        .swap        (swap_c),
        .active_flat (coef_flat),
        .commit_ok_c (commit_ok_c)
    );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl; expectations follow FIR_CTRL_FLUSH_EN if defined.
module tb_fir_coef_ctrl;

`ifdef FIR_CTRL_FLUSH_EN
    localparam int EXP_RST_WAIT = 19;
    localparam int EXP_LOW_CYC  = 20;
    localparam int EXP_HOLD     = 19;
`else
    localparam int EXP_RST_WAIT = 0;
    localparam int EXP_LOW_CYC  = 1;
    localparam int EXP_HOLD     = 0;
`endif

    logic         clk;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [3:0]   cfg_addr;
    logic [15:0]  cfg_data;
    logic         cfg_last;
    logic [255:0] coef_flat;
    logic         yn_valid;
    logic         swap_done;
    logic         cfg_err;

    int n_vec  = 0;
    int n_miss = 0;

    fir_coef_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .coef_flat (coef_flat),
        .yn_valid  (yn_valid),
        .swap_done (swap_done),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] ramp(input int base);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = 16'(base + k);
        return v;
    endfunction

    // Issue one write; holds valid/data until ready, returns the stall count
    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d, input logic l,
                             output int waited);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_last  = l;
        waited    = 0;
        while (!cfg_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cfg_ready) check_eq("ready_timeout", 256'(cfg_ready), 256'(1));
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!yn_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_coef", coef_flat, 256'h1);
        check_eq("rst_swap_done", 256'(swap_done), 256'(0));
        check_eq("rst_cfg_err", 256'(cfg_err), 256'(0));
`ifdef FIR_CTRL_FLUSH_EN
        check_eq("rst_yn_valid", 256'(yn_valid), 256'(0));
        check_eq("rst_cfg_ready", 256'(cfg_ready), 256'(0));
`endif
        rst_n = 1'b1;
    endtask

    logic [255:0] exp_coef;
    int           w;
    int           low;

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        @(negedge clk);

        // Reset then idle: pass-through bank, valid after the flush
        apply_reset();
        wait_valid(w);
        check_eq("rst_valid_delay", 256'(w), 256'(EXP_RST_WAIT));
        check_eq("rst_ready_up", 256'(cfg_ready), 256'(1));

        // Full reload with tap k = k+1
        for (int k = 0; k < 16; k++) cfg_write(4'(k), 16'(k + 1), k == 15, w);
        check_eq("full_swap_k1", 256'(swap_done), 256'(0));
        check_eq("full_yn_k1", 256'(yn_valid), 256'(0));
        check_eq("full_shadow_hidden", coef_flat, 256'h1);
        low = 1;
        @(negedge clk);
        check_eq("full_swap_k2", 256'(swap_done), 256'(1));
        check_eq("full_coef", coef_flat, ramp(1));
        if (!yn_valid) low++;
        @(negedge clk);
        check_eq("full_swap_k3", 256'(swap_done), 256'(0));
        while (!yn_valid && low < 200) begin
            low++;
            @(negedge clk);
        end
        check_eq("full_low_cycles", 256'(low), 256'(EXP_LOW_CYC));

        // Partial load is rejected, then completed
        for (int k = 0; k < 15; k++) cfg_write(4'(k), 16'(16'h100 + k), k == 14, w);
        check_eq("part_err", 256'(cfg_err), 256'(1));
        check_eq("part_ready", 256'(cfg_ready), 256'(1));
        check_eq("part_coef_kept", coef_flat, ramp(1));
        @(negedge clk);
        check_eq("part_err_pulse", 256'(cfg_err), 256'(0));
        cfg_write(4'd15, 16'h10f, 1'b1, w);
        check_eq("retry_err", 256'(cfg_err), 256'(0));
        @(negedge clk);
        check_eq("retry_swap", 256'(swap_done), 256'(1));
        check_eq("retry_coef", coef_flat, ramp(16'h100));

        // Write held during the flush, plus a repeated address
`ifdef FIR_CTRL_FLUSH_EN
        check_eq("hold_ready_low", 256'(cfg_ready), 256'(0));
`endif
        cfg_write(4'd5, 16'hbeef, 1'b0, w);
        check_eq("hold_stall", 256'(w), 256'(EXP_HOLD));
        cfg_write(4'd0, 16'h1111, 1'b0, w);
        for (int k = 0; k < 16; k++) begin
            if (k != 5) cfg_write(4'(k), (k == 0) ? 16'h2222 : 16'(16'h200 + k), k == 15, w);
        end
        exp_coef = ramp(16'h200);
        exp_coef[5*16 +: 16] = 16'hbeef;
        exp_coef[0 +: 16]    = 16'h2222;
        @(negedge clk);
        check_eq("hold_swap", 256'(swap_done), 256'(1));
        check_eq("hold_coef", coef_flat, exp_coef);

        // Reset during the post-swap flush restores pass-through and clears the mask
        apply_reset();
        wait_valid(w);
        check_eq("rst2_valid_delay", 256'(w), 256'(EXP_RST_WAIT));
        cfg_write(4'd3, 16'h0033, 1'b1, w);
        check_eq("rst2_single_err", 256'(cfg_err), 256'(1));
        check_eq("rst2_coef", coef_flat, 256'h1);
        @(negedge clk);
        check_eq("rst2_no_swap", 256'(swap_done), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
